// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes, baud divisor
// and parity helpers used by the UART top and its tick generator.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK_WAIT
  } rx_state_e;

  // Clocks per 1/16-bit tick, rounded to nearest and never below one.
  function automatic int calc_div(input int clk_freq, input int baud);
    int d;
    d = (clk_freq + 8 * baud) / (16 * baud);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic logic parity_of(input logic [7:0] data, input int data_bits, input int mode);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < data_bits) p = p ^ data[i];
    end
    return (mode == PARITY_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_if.sv
// Parallel-side UART bus: transmit request/ready, receive valid/ready and
// the receive status flags. master = user logic, slave = the UART.
interface uart_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, parity_err, frame_err, overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running divider producing a one-clock tick every DIV clocks
// (16 ticks per bit); with DIV=1 the tick is permanently high.
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/uart_param.sv
// Parameterised full-duplex UART: 16x oversampled receiver with break
// detection and a ready/valid transmitter, sharing one baud tick.
module uart_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  uart_if.slave  bus,
  output logic   tx,
  input  logic   rx
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  logic tick;

  uart_baud_gen #(.DIV(DIV)) u_baud_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // ---------------------------------------------------------------- TX
  tx_state_e  tx_state_reg, tx_state_next;
  logic       tx_armed_reg;
  logic [3:0] tx_tick_cnt_reg;
  logic [2:0] tx_bit_idx_reg;
  logic       tx_stop_idx_reg;
  logic [7:0] tx_shift_reg;
  logic       tx_parity_reg;
  logic       tx_fire;
  logic       tx_bit_end;

  assign tx_fire    = bus.tx_valid && bus.tx_ready;
  // Armed covers the wait for the first tick, so the start bit is a full 16 ticks.
  assign tx_bit_end = tick && !tx_armed_reg && (tx_tick_cnt_reg == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state_reg <= TX_IDLE;
    else        tx_state_reg <= tx_state_next;
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    unique case (tx_state_reg)
      TX_IDLE:   if (tx_fire) tx_state_next = TX_START;
      TX_START:  if (tx_bit_end) tx_state_next = TX_DATA;
      TX_DATA:   if (tx_bit_end && tx_bit_idx_reg == LAST_BIT)
                   tx_state_next = (PARITY != PARITY_NONE) ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_bit_end) tx_state_next = TX_STOP;
      TX_STOP:   if (tx_bit_end && tx_stop_idx_reg == LAST_STOP) tx_state_next = TX_IDLE;
      default:   tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_armed_reg    <= 1'b0;
      tx_tick_cnt_reg <= '0;
      tx_bit_idx_reg  <= '0;
      tx_stop_idx_reg <= 1'b0;
      tx_shift_reg    <= '0;
      tx_parity_reg   <= 1'b0;
    end else if (tx_fire) begin
      tx_shift_reg    <= bus.tx_data;
      tx_parity_reg   <= parity_of(bus.tx_data, DATA_BITS, PARITY);
      tx_armed_reg    <= 1'b1;
      tx_tick_cnt_reg <= '0;
      tx_bit_idx_reg  <= '0;
      tx_stop_idx_reg <= 1'b0;
    end else if (tick) begin
      if (tx_armed_reg) begin
        tx_armed_reg    <= 1'b0;
        tx_tick_cnt_reg <= '0;
      end else if (tx_state_reg != TX_IDLE) begin
        tx_tick_cnt_reg <= tx_tick_cnt_reg + 4'd1;
        if (tx_tick_cnt_reg == 4'd15) begin
          if (tx_state_reg == TX_DATA) begin
            tx_shift_reg   <= tx_shift_reg >> 1;
            tx_bit_idx_reg <= tx_bit_idx_reg + 3'd1;
          end
          if (tx_state_reg == TX_STOP) tx_stop_idx_reg <= ~tx_stop_idx_reg;
        end
      end
    end
  end

  always_comb begin
    bus.tx_ready = (tx_state_reg == TX_IDLE);
    unique case (tx_state_reg)
      TX_START:  tx = tx_armed_reg;
      TX_DATA:   tx = tx_shift_reg[0];
      TX_PARITY: tx = tx_parity_reg;
      default:   tx = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- RX
  logic [1:0] rx_sync_reg;
  logic       rx_s;
  rx_state_e  rx_state_reg, rx_state_next;
  logic [3:0] rx_tick_cnt_reg;
  logic [2:0] rx_bit_idx_reg;
  logic [7:0] rx_shift_reg;
  logic       rx_par_reg;
  logic       rx_sample;
  logic       frame_load;
  logic       rx_pending_reg;
  logic       rx_valid_reg;
  logic [7:0] rx_data_reg;
  logic       parity_err_reg;
  logic       frame_err_reg;
  logic       overrun_reg;

  // Preset to idle-high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync_reg <= 2'b11;
    else        rx_sync_reg <= {rx_sync_reg[0], rx};
  end
  assign rx_s = rx_sync_reg[1];

  assign rx_sample  = tick && ((rx_state_reg == RX_START) ? (rx_tick_cnt_reg == 4'd7)
                                                          : (rx_tick_cnt_reg == 4'd15));
  assign frame_load = rx_sample && (rx_state_reg == RX_STOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state_reg <= RX_IDLE;
    else        rx_state_reg <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    unique case (rx_state_reg)
      RX_IDLE:       if (tick && !rx_s) rx_state_next = RX_START;
      RX_START:      if (rx_sample) rx_state_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:       if (rx_sample && rx_bit_idx_reg == LAST_BIT)
                       rx_state_next = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
      RX_PARITY:     if (rx_sample) rx_state_next = RX_STOP;
      // A low stop bit over all-zero data is a break: hold off until the line recovers.
      RX_STOP:       if (rx_sample)
                       rx_state_next = (!rx_s && rx_shift_reg == 8'd0) ? RX_BREAK_WAIT : RX_IDLE;
      RX_BREAK_WAIT: if (tick && rx_s) rx_state_next = RX_IDLE;
      default:       rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_tick_cnt_reg <= '0;
      rx_bit_idx_reg  <= '0;
      rx_shift_reg    <= '0;
      rx_par_reg      <= 1'b0;
    end else if (rx_state_reg == RX_IDLE) begin
      rx_tick_cnt_reg <= '0;
      rx_bit_idx_reg  <= '0;
    end else if (tick) begin
      rx_tick_cnt_reg <= rx_sample ? 4'd0 : rx_tick_cnt_reg + 4'd1;
      if (rx_sample && rx_state_reg == RX_DATA) begin
        rx_shift_reg[rx_bit_idx_reg] <= rx_s;
        rx_bit_idx_reg               <= rx_bit_idx_reg + 3'd1;
      end
      if (rx_sample && rx_state_reg == RX_PARITY) rx_par_reg <= rx_s;
    end
  end

  // Data and flags load on the stop sample; valid follows one clock later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_reg    <= '0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      rx_pending_reg <= 1'b0;
      rx_valid_reg   <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      if (frame_load) begin
        rx_data_reg    <= rx_shift_reg;
        parity_err_reg <= (PARITY != PARITY_NONE) &&
                          (rx_par_reg != parity_of(rx_shift_reg, DATA_BITS, PARITY));
        frame_err_reg  <= !rx_s;
      end
      rx_pending_reg <= frame_load;
      overrun_reg    <= frame_load && rx_valid_reg && !bus.rx_ready;
      if (rx_valid_reg && bus.rx_ready) rx_valid_reg <= 1'b0;
      else if (rx_pending_reg)          rx_valid_reg <= 1'b1;
    end
  end

  always_comb begin
    bus.rx_data    = rx_data_reg;
    bus.rx_valid   = rx_valid_reg;
    bus.parity_err = parity_err_reg;
    bus.frame_err  = frame_err_reg;
    bus.overrun    = overrun_reg;
  end

endmodule

// File: doc/uart_param.md
UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 Parameter CLK_FREQ, 50_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD, 115200, line rate in bit/s.
REQ-003 Parameter DATA_BITS, 8, data bits per frame; legal range 5..8.
REQ-004 Parameter PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
REQ-006 Port clk  in  1  single clock; all logic in this one domain; one clock, reset asynchronous and active-low.
REQ-007 Port rst_n  in  1  asynchronous active-low reset.
REQ-008 Port tx_data  in  8  transmit byte; only bits [DATA_BITS-1:0] are sent.
REQ-009 Port tx_valid  in  1  transmit request.
REQ-010 Port tx_ready  out  1  transmitter idle; accepts a request.
REQ-011 Port rx_data  out  8  received byte, zero-extended above DATA_BITS.
REQ-012 Port rx_valid  out  1  rx_data is held and valid.
REQ-013 Port rx_ready  in  1  consumer accepts rx_data.
REQ-014 Port parity_err  out  1  qualifies rx_valid: the held frame failed the parity check.
REQ-015 Port frame_err  out  1  qualifies rx_valid: the held frame's stop bit was sampled low.
REQ-016 Port overrun  out  1  one-cycle pulse: an unread frame was overwritten.
REQ-017 Port tx  out  1  serial output; idle high.
REQ-018 Port rx  in  1  serial input, asynchronous to clk.

Function
REQ-019 The block SHALL generate a one-cycle tick every DIV = round(CLK_FREQ/(16*BAUD)) clocks, with DIV >= 1; one bit = 16 ticks.
REQ-020 A transmit handshake SHALL occur on a clock where tx_valid and tx_ready are both high; tx_data is latched on that edge.
REQ-021 tx_ready SHALL fall on the clock after the handshake and rise on the clock after the last stop bit ends.
REQ-022 The TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-023 tx SHALL go low on the first tick after the handshake, so start-bit jitter is at most one tick.
REQ-024 Each TX bit SHALL last exactly 16 ticks; data is sent LSB first, then the parity bit (if any), then STOP_BITS high bits.
REQ-025 Parity SHALL be the XOR of the DATA_BITS data bits for even mode, and its inverse for odd mode.
REQ-026 rx SHALL pass through a 2-flop synchroniser before any use; the block's internal logic SHALL have no other asynchronous input.
REQ-027 The RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
REQ-028 RX leaves IDLE when synchronised rx is low on a tick.
REQ-029 RX SHALL sample 8 ticks later (mid start bit); if rx is high there, it SHALL treat the start as false and return to IDLE with no output.
REQ-030 Each subsequent RX bit SHALL be sampled at 16-tick intervals from the mid-start sample.
REQ-031 RX SHALL check only the first stop bit; a second stop bit, when configured, is not checked.
REQ-032 On the first-stop sample, rx_data, parity_err and frame_err SHALL load together and rx_valid SHALL set on the next clock.
REQ-033 rx_valid SHALL stay high until a clock with rx_ready high, then clear on the following clock.
REQ-034 If a new frame completes while rx_valid is high and rx_ready is low, the new frame SHALL overwrite the held data and overrun SHALL pulse for one cycle.
REQ-035 A completing frame coincident with rx_ready high SHALL load normally with no overrun.
REQ-036 If frame_err is set and all data bits are 0 (break), RX SHALL enter BREAK_WAIT and return to IDLE only after rx is sampled high.
REQ-037 TX and RX SHALL operate fully independently (full duplex).

Reset
REQ-038 While rst_n is low the block SHALL drive: tx=1, tx_ready=1, rx_valid=0, rx_data=0, parity_err=0, frame_err=0, overrun=0.
REQ-039 While rst_n is low both FSMs SHALL be in IDLE and the tick counter at 0.
REQ-040 Reset mid-frame SHALL abort the frame immediately, with no partial output.
REQ-041 After reset release the synchroniser flops SHALL read 1 (preset), preventing a false start.

Structure
REQ-042 Package uart_pkg SHALL hold the TX/RX state encodings, the parity-mode constants and the DIV calculation function.
REQ-043 The tick generator SHALL be the sub-module uart_baud_gen (ports clk, rst_n, tick; parameter DIV).
REQ-044 TX and RX SHALL be inline FSMs in uart_param.

Verification (CLK_FREQ=1_600_000, BAUD=100_000, so DIV=1 and one bit = 16 clocks)
REQ-045 8N1: send 0xA5 looped tx->rx -> tx low for 16 clocks, bits 1,0,1,0,0,1,0,1 LSB first, 16 high; rx_valid with rx_data=0xA5 and no errors; tx_ready high again 160+/-1 clocks after the handshake.
REQ-046 7O2: send 0x35 -> 7 data bits then parity bit 1 then two stop bits; receiver sees 0x35 with parity_err=0; a flipped parity bit gives parity_err=1.
REQ-047 8N1: drive a 6-clock low glitch on rx -> no rx_valid; RX returns to IDLE.
REQ-048 8N1: drive 0x00 with the stop bit low, then rx held low for 400 clocks -> rx_valid with frame_err=1; no further frames until rx high, then a 0x5A frame is received correctly.
REQ-049 8N1: receive 0x11 then 0x22 with rx_ready held 0 -> overrun pulses once and rx_data=0x22; rx_valid clears the clock after rx_ready=1.
REQ-050 8N1: assert rst_n low at bit 4 of a TX frame -> tx=1 and tx_ready=1 immediately; the next request transmits a clean frame.
